// File: rtl/sweep_result_buffer.sv
// Point-indexed capture buffer for frequency-sweep results.
// Tracks the magnitude extremes, sweep state and sticky errors, and has a registered random-access read port.
module sweep_result_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_POINTS = 200
) (
  input  logic                  clk125,
  input  logic                  areset,
  input  logic                  clear,
  input  logic                  valid_m,
  input  logic [DATA_WIDTH-1:0] modulo,
  input  logic [DATA_WIDTH-1:0] phase,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic                  fin,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic                  rd_hit,
  output logic [DATA_WIDTH-1:0] rd_modulo,
  output logic [DATA_WIDTH-1:0] rd_phase,
  output logic [ADDR_WIDTH:0]   points_stored,
  output logic                  busy,
  output logic                  sweep_done,
  output logic [DATA_WIDTH-1:0] min_modulo,
  output logic [DATA_WIDTH-1:0] max_modulo,
  output logic [ADDR_WIDTH-1:0] min_index,
  output logic [ADDR_WIDTH-1:0] max_index,
  output logic                  err_range,
  output logic                  err_dup,
  output logic                  err_overrun
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] NP    = NUM_POINTS[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] P_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;
  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] r_mem_mod [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_ph  [DEPTH];
  logic [DEPTH-1:0]      r_vbits;

  logic [ADDR_WIDTH:0]   r_points;
  logic [DATA_WIDTH-1:0] r_min, r_max;
  logic [ADDR_WIDTH-1:0] r_min_idx, r_max_idx;
  logic                  r_have_ext;
  logic                  r_err_range, r_err_dup, r_err_overrun;
  logic                  r_rd_valid, r_rd_hit;
  logic [DATA_WIDTH-1:0] r_rd_mod, r_rd_ph;

  logic w_cap, w_in_range, w_wr, w_dup;

  always_ff @(posedge clk125 or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // clear has priority over fin, so a simultaneous clear re-arms the sweep
  always_comb begin
    w_next = r_state;
    if (clear) w_next = S_CAPTURE;
    else begin
      case (r_state)
        S_CAPTURE: if (fin) w_next = S_DONE;
        default:   ;
      endcase
    end
  end

  assign w_cap      = (r_state == S_CAPTURE) && valid_m && !clear;
  assign w_in_range = ({1'b0, index} < NP);
  assign w_wr       = w_cap && w_in_range;
  assign w_dup      = r_vbits[index];

  // Data arrays carry no reset so they map onto block RAM
  always_ff @(posedge clk125) begin
    if (w_wr) begin
      r_mem_mod[index] <= modulo;
      r_mem_ph[index]  <= phase;
    end
    if (rd_req) begin
      r_rd_mod <= r_mem_mod[rd_addr];
      r_rd_ph  <= r_mem_ph[rd_addr];
    end
  end

  always_ff @(posedge clk125 or posedge areset) begin
    if (areset) begin
      r_vbits       <= '0;
      r_points      <= '0;
      r_min         <= '0;
      r_max         <= '0;
      r_min_idx     <= '0;
      r_max_idx     <= '0;
      r_have_ext    <= 1'b0;
      r_err_range   <= 1'b0;
      r_err_dup     <= 1'b0;
      r_err_overrun <= 1'b0;
    end else if (clear) begin
      r_vbits       <= '0;
      r_points      <= '0;
      r_min         <= '0;
      r_max         <= '0;
      r_min_idx     <= '0;
      r_max_idx     <= '0;
      r_have_ext    <= 1'b0;
      r_err_range   <= 1'b0;
      r_err_dup     <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_vbits[index] <= 1'b1;
        if (w_dup)                  r_err_dup <= 1'b1;
        else if (r_points != P_MAX) r_points  <= r_points + 1'b1;
        // Strict compares: on a tie the earlier index is kept
        if (!r_have_ext) begin
          r_have_ext <= 1'b1;
          r_min      <= modulo;
          r_max      <= modulo;
          r_min_idx  <= index;
          r_max_idx  <= index;
        end else begin
          if ($signed(modulo) < $signed(r_min)) begin
            r_min     <= modulo;
            r_min_idx <= index;
          end
          if ($signed(modulo) > $signed(r_max)) begin
            r_max     <= modulo;
            r_max_idx <= index;
          end
        end
      end
      if (w_cap && !w_in_range)            r_err_range   <= 1'b1;
      if (valid_m && r_state != S_CAPTURE) r_err_overrun <= 1'b1;
    end
  end

  // The hit bit is sampled before this edge's write, so reads see old contents
  always_ff @(posedge clk125 or posedge areset) begin
    if (areset) begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) r_rd_hit <= r_vbits[rd_addr];
    end
  end

  assign rd_valid      = r_rd_valid;
  assign rd_hit        = r_rd_hit;
  assign rd_modulo     = r_rd_hit ? r_rd_mod : '0;
  assign rd_phase      = r_rd_hit ? r_rd_ph  : '0;
  assign points_stored = r_points;
  assign busy          = (r_state == S_CAPTURE);
  assign sweep_done    = (r_state == S_DONE);
  assign min_modulo    = r_min;
  assign max_modulo    = r_max;
  assign min_index     = r_min_idx;
  assign max_index     = r_max_idx;
  assign err_range     = r_err_range;
  assign err_dup       = r_err_dup;
  assign err_overrun   = r_err_overrun;

endmodule

// File: tb/tb_sweep_result_buffer.sv
// Directed bench for sweep_result_buffer: hand-computed expectations checked with immediate assertions.
module tb_sweep_result_buffer;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk125 = 1'b0;
  logic          areset, clear, valid_m, fin, rd_req;
  logic [DW-1:0] modulo, phase;
  logic [AW-1:0] index, rd_addr;
  logic          rd_valid, rd_hit, busy, sweep_done;
  logic [DW-1:0] rd_modulo, rd_phase, min_modulo, max_modulo;
  logic [AW:0]   points_stored;
  logic [AW-1:0] min_index, max_index;
  logic          err_range, err_dup, err_overrun;

  int checks = 0;
  int errors = 0;

  always #4 clk125 = ~clk125;

  sweep_result_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_POINTS(200)) dut (
    .clk125(clk125), .areset(areset), .clear(clear), .valid_m(valid_m),
    .modulo(modulo), .phase(phase), .index(index), .fin(fin),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_hit(rd_hit),
    .rd_modulo(rd_modulo), .rd_phase(rd_phase), .points_stored(points_stored),
    .busy(busy), .sweep_done(sweep_done), .min_modulo(min_modulo),
    .max_modulo(max_modulo), .min_index(min_index), .max_index(max_index),
    .err_range(err_range), .err_dup(err_dup), .err_overrun(err_overrun)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wr(input int idx, input int m, input int p);
    valid_m = 1'b1;
    index   = 8'(idx);
    modulo  = m;
    phase   = p;
    tick();
    valid_m = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_req  = 1'b1;
    rd_addr = 8'(a);
    tick();
    rd_req  = 1'b0;
  endtask

  initial begin
    areset = 1'b1; clear = 1'b0; valid_m = 1'b0; fin = 1'b0; rd_req = 1'b0;
    modulo = '0; phase = '0; index = '0; rd_addr = '0;
    repeat (2) tick();
    areset = 1'b0;
    tick();

    chk("rst_busy", busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_points", points_stored, 0);
    chk("rst_min", min_modulo, 0);
    chk("rst_max", max_modulo, 0);
    chk("rst_errs", {err_range, err_dup, err_overrun}, 0);
    chk("rst_rdvalid", rd_valid, 0);
    chk("rst_rdmod", rd_modulo, 0);

    // Full 200-point sweep
    do_clear();
    chk("arm_busy", busy, 1);
    for (int i = 0; i < 200; i++) wr(i, i * 10 - 500, -i);
    fin = 1'b1;
    tick();
    fin = 1'b0;
    chk("full_done", sweep_done, 1);
    chk("full_busy", busy, 0);
    chk("full_points", points_stored, 200);
    chk("full_min", min_modulo, -500);
    chk("full_min_idx", min_index, 0);
    chk("full_max", max_modulo, 1490);
    chk("full_max_idx", max_index, 199);
    chk("full_errs", {err_range, err_dup, err_overrun}, 0);

    rd(57);
    chk("rd57_valid", rd_valid, 1);
    chk("rd57_hit", rd_hit, 1);
    chk("rd57_mod", rd_modulo, 70);
    chk("rd57_ph", rd_phase, -57);
    tick();
    chk("rd57_pulse", rd_valid, 0);
    chk("rd57_hold", rd_modulo, 70);
    rd(210);
    chk("rd210_hit", rd_hit, 0);
    chk("rd210_mod", rd_modulo, 0);
    chk("rd210_ph", rd_phase, 0);

    // Sample while DONE is rejected
    wr(3, 999, 1);
    chk("ovr_flag", err_overrun, 1);
    chk("ovr_points", points_stored, 200);
    rd(3);
    chk("ovr_mem", rd_modulo, -470);

    // clear and valid_m together: sample dropped, flags cleared
    clear = 1'b1;
    wr(0, 12345, 0);
    clear = 1'b0;
    chk("clrv_points", points_stored, 0);
    chk("clrv_ovr", err_overrun, 0);
    chk("clrv_busy", busy, 1);
    chk("clrv_max", max_modulo, 0);
    rd(0);
    chk("clrv_hit", rd_hit, 0);

    // Duplicate and out-of-range writes
    wr(5, 100, 1);
    wr(5, 300, 2);
    chk("dup_flag", err_dup, 1);
    chk("dup_points", points_stored, 1);
    chk("dup_min", min_modulo, 100);
    chk("dup_max", max_modulo, 300);
    rd(5);
    chk("dup_mod", rd_modulo, 300);
    wr(220, 7, 7);
    chk("range_flag", err_range, 1);
    chk("range_points", points_stored, 1);
    chk("range_max", max_modulo, 300);

    // Ties keep the earlier index; fin together with valid_m
    do_clear();
    chk("clr_errs", {err_range, err_dup, err_overrun}, 0);
    wr(3, 800, 0);
    wr(9, 800, 0);
    chk("tie_max_idx", max_index, 3);
    chk("tie_min_idx", min_index, 3);
    fin = 1'b1;
    wr(10, 50, -10);
    fin = 1'b0;
    chk("finv_done", sweep_done, 1);
    chk("finv_points", points_stored, 3);
    chk("finv_min", min_modulo, 50);
    chk("finv_min_idx", min_index, 10);
    rd(10);
    chk("finv_hit", rd_hit, 1);
    chk("finv_mod", rd_modulo, 50);

    // Read-before-write on the same address
    do_clear();
    wr(7, 11, 1);
    rd_req = 1'b1; rd_addr = 8'd7;
    wr(7, 22, 2);
    rd_req = 1'b0;
    chk("rbw_hit", rd_hit, 1);
    chk("rbw_old", rd_modulo, 11);
    rd(7);
    chk("rbw_new", rd_modulo, 22);
    rd_req = 1'b1; rd_addr = 8'd8;
    wr(8, 33, 3);
    rd_req = 1'b0;
    chk("rbw_oldvalid", rd_hit, 0);

    // Asynchronous reset in the middle of a capture
    do_clear();
    for (int i = 0; i < 50; i++) wr(i, i, i);
    chk("mid_points", points_stored, 50);
    areset = 1'b1;
    #1;
    chk("arst_points", points_stored, 0);
    chk("arst_busy", busy, 0);
    chk("arst_max", max_modulo, 0);
    chk("arst_maxidx", max_index, 0);
    @(negedge clk125);
    areset = 1'b0;
    tick();
    chk("arst_idle", busy, 0);
    do_clear();
    rd(20);
    chk("arst_rd_valid", rd_valid, 1);
    chk("arst_rd_hit", rd_hit, 0);
    chk("arst_rd_mod", rd_modulo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sweep_result_buffer.md
Name: sweep_result_buffer

Overview:
- Sits directly downstream of the frequency-sweep measurement control path.
- Captures each per-frequency result (magnitude ratio MODULO, PHASE, point index) when the valid pulse fires, and stores it in a point-indexed memory.
- Tracks min/max magnitude and their indices (resonance/antiresonance) and flags sweep completion.
- Exposes a random-access read port with a request/valid handshake for the host/readout logic.

Parameters:
- DATA_WIDTH, 32, width of the magnitude and phase words.
- ADDR_WIDTH, 8, point index width; memory depth is 2**ADDR_WIDTH.
- NUM_POINTS, 200, number of valid sweep points; indices >= NUM_POINTS are out of range.

Ports:
- clk125  in  1  system clock, all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous pulse: arm a new sweep.
- valid_m  in  1  one-cycle pulse: result on modulo/phase/index is valid.
- modulo  in  DATA_WIDTH  signed magnitude result.
- phase  in  DATA_WIDTH  signed phase result.
- index  in  ADDR_WIDTH  frequency point index of the result.
- fin  in  1  one-cycle pulse: sweep finished.
- rd_req  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_valid  out  1  read data valid, 1 cycle after rd_req.
- rd_hit  out  1  entry at rd_addr was written this sweep.
- rd_modulo  out  DATA_WIDTH  stored magnitude.
- rd_phase  out  DATA_WIDTH  stored phase.
- points_stored  out  ADDR_WIDTH+1  count of distinct entries written.
- busy  out  1  state == CAPTURE.
- sweep_done  out  1  state == DONE.
- min_modulo, max_modulo  out  DATA_WIDTH  extreme magnitudes this sweep.
- min_index, max_index  out  ADDR_WIDTH  indices of the extremes.
- err_range, err_dup, err_overrun  out  1  sticky error flags.

Behaviour:
- Reset: state IDLE; all outputs 0; all per-entry valid bits 0. Memory contents are don't-care. Reset mid-capture aborts immediately.
- FSM states:
  - IDLE: clear -> CAPTURE.
  - CAPTURE: fin -> DONE; clear -> CAPTURE (re-arm).
  - DONE: clear -> CAPTURE.
- clear (any state): next cycle clears valid bits, points_stored, min/max, err flags, and sweep_done. A valid_m in the same cycle as clear is dropped.
- Capture (CAPTURE only, valid_m=1):
  - index >= NUM_POINTS: no write; err_range<=1.
  - Entry already valid: overwrite data; err_dup<=1; points_stored unchanged.
  - Otherwise: write modulo/phase, set valid bit, points_stored+1.
- Min/max:
  - First accepted sample of a sweep loads both min and max.
  - After that, signed strict compare; ties keep the earlier index.
  - Out-of-range samples are excluded.
- valid_m in IDLE or DONE: ignored; err_overrun<=1, except a valid_m in the same cycle as clear, which is simply dropped.
- fin together with valid_m in CAPTURE: the sample is captured first, then the state goes to DONE in the same edge.
- fin outside CAPTURE: ignored.
- Read port:
  - rd_req accepted every cycle, in any state, with no backpressure.
  - rd_valid pulses exactly 1 cycle later; rd_modulo, rd_phase, rd_hit are registered and held until the next rd_req.
  - rd_hit=0 returns zeros on the data outputs.
  - A read and a write to the same address in the same cycle return the OLD data and the OLD valid bit (read-before-write).
- Width rules:
  - points_stored saturates at 2**ADDR_WIDTH.
  - No arithmetic on data; values are stored bit-exact.
- Memory is single clock, one write port and one read port, inferable as block RAM. Valid bits are held in flops.

Test Plan:
- Reset, clear, then valid_m at index 0..199 with modulo=index*10-500, phase=-index -> sweep_done after fin; points_stored=200; min_modulo=-500/min_index=0; max_modulo=1490/max_index=199; all errors 0.
- Read back rd_addr=57 -> 1 cycle later rd_valid=1, rd_hit=1, rd_modulo=70, rd_phase=-57. Read rd_addr=210 -> rd_hit=0, data 0.
- Write index 5 twice (modulo 100, then 300) -> err_dup=1, points_stored=1, read returns 300. Then index 220 -> err_range=1, no count change.
- Equal maxima 800 at index 3, then index 9 -> max_index=3. fin and valid_m in the same cycle (index 10) -> entry 10 stored and sweep_done=1 next cycle.
- valid_m in DONE -> err_overrun=1, memory unchanged. clear together with valid_m -> sample dropped, points_stored=0, flags cleared.
- Assert areset mid-CAPTURE after 50 points -> state IDLE, points_stored=0, outputs 0. Read at address 20 after clear -> rd_hit=0. Read and write of address 7 in the same cycle -> returns old data.
